// File: rtl/flappy_pkg.sv
// Shared game-wide types and geometry constants for the flappy pipeline.
package flappy_pkg;
    localparam int X_W      = 11;
    localparam int Y_W      = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        GS_START  = 2'b00,
        GS_ACTIVE = 2'b01,
        GS_OVER   = 2'b10
    } game_state_t;
endpackage

// File: rtl/pipe_scheduler_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to randomise pipe gap height.
module lfsr16 (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        en,
    output logic [15:0] q
);
    localparam logic [15:0] SEED = 16'hACE1;

    logic feedback;
    assign feedback = q[0] ^ q[2] ^ q[3] ^ q[5];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            q <= SEED;
        end else if (en) begin
            q <= {feedback, q[15:1]};
        end
    end
endmodule

// File: rtl/pipe_scheduler.sv
// Pipe slot pool: spawns on a frame cadence, scrolls left, retires off-screen
// and counts score as pipes pass the bird.
module pipe_scheduler
    import flappy_pkg::X_W, flappy_pkg::Y_W, flappy_pkg::GS_START, flappy_pkg::GS_ACTIVE;
#(
    parameter int NUM_PIPES    = 4,
    parameter int SPAWN_FRAMES = 90,
    parameter int SCROLL_SPEED = 2,
    parameter int SCREEN_W     = flappy_pkg::SCREEN_W,
    parameter int PIPE_W       = 52,
    parameter int GAP_MIN      = 100,
    parameter int BIRD_X       = 160
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [1:0]               game_state,
    input  logic                     frame_tick,
    output logic [NUM_PIPES-1:0]     pipe_valid,
    output logic [X_W*NUM_PIPES-1:0] pipe_x_flat,
    output logic [Y_W*NUM_PIPES-1:0] pipe_gap_flat,
    output logic [7:0]               score,
    output logic                     score_pulse
);
    localparam int CNT_W = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SPAWN_FRAMES - 1);
    localparam logic signed [X_W-1:0] RETIRE_X = X_W'(-PIPE_W);
    // x + PIPE_W < BIRD_X rewritten as x < BIRD_X - PIPE_W so nothing can overflow.
    localparam logic signed [X_W-1:0] PASS_X   = X_W'(BIRD_X - PIPE_W);

    logic [15:0]          lfsr_q;
    logic                 start_page;
    logic                 active_tick;
    logic [CNT_W-1:0]     spawn_cnt_reg;
    logic                 spawn_due;
    logic [Y_W-1:0]       spawn_gap;
    logic [NUM_PIPES-1:0] free_slot;
    logic [NUM_PIPES-1:0] spawn_sel;
    logic [NUM_PIPES-1:0] qualify;
    logic [8:0]           pass_cnt;
    logic [8:0]           score_sum;
    logic [7:0]           score_next;
    logic [7:0]           score_reg;
    logic                 pulse_reg;
    logic                 unused_lfsr;

    assign start_page  = (game_state == GS_START);
    assign active_tick = (game_state == GS_ACTIVE) && frame_tick;

    lfsr16 u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .en    (frame_tick),
        .q     (lfsr_q)
    );

    assign spawn_gap   = Y_W'(GAP_MIN) + {3'b000, lfsr_q[6:0]};
    assign unused_lfsr = ^lfsr_q[15:7];

    assign spawn_due = (spawn_cnt_reg == CNT_LAST);

    // Preloaded to the last count so the first active tick spawns at once.
    always_ff @(posedge Clk) begin
        if (Reset || start_page) begin
            spawn_cnt_reg <= CNT_LAST;
        end else if (active_tick) begin
            spawn_cnt_reg <= spawn_due ? '0 : spawn_cnt_reg + CNT_W'(1);
        end
    end

    // Lowest-index free slot, isolated as a one-hot by x & -x.
    assign spawn_sel = free_slot & (~free_slot + NUM_PIPES'(1));

    for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_slot
        logic signed [X_W-1:0] x_reg;
        logic signed [X_W-1:0] x_scrolled;
        logic [Y_W-1:0]        gap_reg;
        logic                  valid_reg;
        logic                  scored_reg;
        logic                  retire;

        assign x_scrolled    = x_reg - X_W'(SCROLL_SPEED);
        assign retire        = valid_reg && (x_scrolled <= RETIRE_X);
        assign qualify[gi]   = valid_reg && !scored_reg && (x_scrolled < PASS_X);
        assign free_slot[gi] = !valid_reg || retire;

        always_ff @(posedge Clk) begin
            if (Reset || start_page) begin
                valid_reg  <= 1'b0;
                scored_reg <= 1'b0;
                x_reg      <= '0;
                gap_reg    <= '0;
            end else if (active_tick) begin
                if (spawn_due && spawn_sel[gi]) begin
                    valid_reg  <= 1'b1;
                    scored_reg <= 1'b0;
                    x_reg      <= X_W'(SCREEN_W);
                    gap_reg    <= spawn_gap;
                end else if (valid_reg) begin
                    valid_reg  <= !retire;
                    scored_reg <= !retire && (scored_reg || qualify[gi]);
                    x_reg      <= x_scrolled;
                end
            end
        end

        assign pipe_valid[gi]               = valid_reg;
        assign pipe_x_flat[X_W*gi +: X_W]   = x_reg;
        assign pipe_gap_flat[Y_W*gi +: Y_W] = gap_reg;
    end

    always_comb begin
        pass_cnt = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            pass_cnt = pass_cnt + 9'(qualify[i]);
        end
    end

    assign score_sum  = {1'b0, score_reg} + pass_cnt;
    assign score_next = score_sum[8] ? 8'hFF : score_sum[7:0];

    always_ff @(posedge Clk) begin
        if (Reset || start_page) begin
            score_reg <= '0;
            pulse_reg <= 1'b0;
        end else if (active_tick) begin
            score_reg <= score_next;
            pulse_reg <= (score_next != score_reg);
        end else begin
            pulse_reg <= 1'b0;
        end
    end

    assign score       = score_reg;
    assign score_pulse = pulse_reg;
endmodule

// File: tb/tb_pipe_scheduler.sv
// Drives three differently-parameterised schedulers in lockstep and checks them
// against a slot-pool reference model.
module tb_pipe_scheduler;
    localparam int ND = 3;
    localparam int NP = 4;
    localparam int PIPE_W = 52;
    localparam int BIRD_X = 160;

    int P_SPAWN  [ND] = '{90, 10, 1};
    int P_SCROLL [ND] = '{2, 1, 64};
    int P_SCREEN [ND] = '{640, 640, 100};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] game_state = 2'b00;
    logic       frame_tick = 1'b0;

    logic [NP-1:0]    valid_o [ND];
    logic [11*NP-1:0] x_o     [ND];
    logic [10*NP-1:0] gap_o   [ND];
    logic [7:0]       score_o [ND];
    logic             pulse_o [ND];

    int tests = 0;
    int failed = 0;
    int tick_no = -1;

    // Reference model state
    bit          m_valid  [ND][NP];
    bit          m_scored [ND][NP];
    int          m_x      [ND][NP];
    int          m_gap    [ND][NP];
    int          m_score  [ND];
    bit          m_pulse  [ND];
    int          m_cnt    [ND];
    logic [15:0] m_lfsr   [ND];

    always #5 clk = ~clk;

    pipe_scheduler u_dut0 (
        .Clk(clk), .Reset(reset), .game_state(game_state), .frame_tick(frame_tick),
        .pipe_valid(valid_o[0]), .pipe_x_flat(x_o[0]), .pipe_gap_flat(gap_o[0]),
        .score(score_o[0]), .score_pulse(pulse_o[0]));

    pipe_scheduler #(.SPAWN_FRAMES(10), .SCROLL_SPEED(1)) u_dut1 (
        .Clk(clk), .Reset(reset), .game_state(game_state), .frame_tick(frame_tick),
        .pipe_valid(valid_o[1]), .pipe_x_flat(x_o[1]), .pipe_gap_flat(gap_o[1]),
        .score(score_o[1]), .score_pulse(pulse_o[1]));

    pipe_scheduler #(.SPAWN_FRAMES(1), .SCROLL_SPEED(64), .SCREEN_W(100)) u_dut2 (
        .Clk(clk), .Reset(reset), .game_state(game_state), .frame_tick(frame_tick),
        .pipe_valid(valid_o[2]), .pipe_x_flat(x_o[2]), .pipe_gap_flat(gap_o[2]),
        .score(score_o[2]), .score_pulse(pulse_o[2]));

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    task automatic clear_model(input int d);
        for (int s = 0; s < NP; s++) begin
            m_valid[d][s] = 0; m_scored[d][s] = 0; m_x[d][s] = 0; m_gap[d][s] = 0;
        end
        m_score[d] = 0;
        m_pulse[d] = 0;
        m_cnt[d]   = P_SPAWN[d] - 1;
    endtask

    task automatic model_update(input int d, input logic r, input logic [1:0] st, input logic tk);
        int k;
        int nx;
        int ns;
        bit placed;
        logic [15:0] pre;
        m_pulse[d] = 0;
        if (r) begin
            clear_model(d);
            m_lfsr[d] = 16'hACE1;
            return;
        end
        pre = m_lfsr[d];
        if (tk) m_lfsr[d] = lfsr_next(m_lfsr[d]);
        if (st == 2'b00) begin
            clear_model(d);
            return;
        end
        if (st != 2'b01 || !tk) return;
        k = 0;
        for (int s = 0; s < NP; s++) begin
            if (m_valid[d][s]) begin
                nx = m_x[d][s] - P_SCROLL[d];
                m_x[d][s] = nx;
                if (!m_scored[d][s] && nx + PIPE_W < BIRD_X) begin
                    k++;
                    m_scored[d][s] = 1;
                end
                if (nx <= -PIPE_W) begin
                    m_valid[d][s] = 0;
                    m_scored[d][s] = 0;
                end
            end
        end
        if (m_cnt[d] == P_SPAWN[d] - 1) begin
            m_cnt[d] = 0;
            placed = 0;
            for (int s = 0; s < NP; s++) begin
                if (!placed && !m_valid[d][s]) begin
                    placed = 1;
                    m_valid[d][s] = 1; m_scored[d][s] = 0;
                    m_x[d][s] = P_SCREEN[d];
                    m_gap[d][s] = 100 + int'(pre[6:0]);
                end
            end
        end else begin
            m_cnt[d]++;
        end
        ns = m_score[d] + k;
        if (ns > 255) ns = 255;
        m_pulse[d] = (ns != m_score[d]);
        m_score[d] = ns;
    endtask

    // Called at a negedge; returns at the next negedge with outputs settled.
    task automatic step(input logic r, input logic [1:0] st, input logic tk);
        reset = r; game_state = st; frame_tick = tk;
        @(posedge clk);
        for (int d = 0; d < ND; d++) model_update(d, r, st, tk);
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic drive_tick(input logic [1:0] st);
        int idle;
        idle = $urandom_range(0, 2);
        repeat (idle) step(1'b0, st, 1'b0);
        step(1'b0, st, 1'b1);
    endtask

    task automatic test_reset();
        step(1'b1, 2'b01, 1'b1);
        step(1'b1, 2'b00, 1'b0);
        for (int d = 0; d < ND; d++) begin
            tests++;
            if (valid_o[d] !== '0 || x_o[d] !== '0 || gap_o[d] !== '0 || score_o[d] !== 8'd0 || pulse_o[d] !== 1'b0) begin
                failed++;
                $display("FAIL reset dut%0d: got valid=%b x=%h gap=%h score=%0d pulse=%b, expected all zero",
                         d, valid_o[d], x_o[d], gap_o[d], score_o[d], pulse_o[d]);
            end
        end
    endtask

    task automatic test_seed_gap(input string tag);
        step(1'b0, 2'b01, 1'b1);
        tests++;
        if (valid_o[0] !== 4'b0001 || x_o[0][10:0] !== 11'd640 || gap_o[0][9:0] !== 10'd197 || score_o[0] !== 8'd0) begin
            failed++;
            $display("FAIL %s: got valid=%b x0=%0d gap0=%0d score=%0d, expected 0001/640/197/0",
                     tag, valid_o[0], x_o[0][10:0], gap_o[0][9:0], score_o[0]);
        end
    endtask

    task automatic test_start_page();
        for (int i = 0; i < 5; i++) begin
            drive_tick(2'b00);
            for (int d = 0; d < ND; d++) begin
                tests++;
                if (valid_o[d] !== '0 || score_o[d] !== 8'd0 || pulse_o[d] !== 1'b0) begin
                    failed++;
                    $display("FAIL start_page dut%0d tick %0d: got valid=%b score=%0d pulse=%b, expected cleared",
                             d, i, valid_o[d], score_o[d], pulse_o[d]);
                end
            end
        end
    endtask

    task automatic test_first_spawn();
        drive_tick(2'b01);
        tick_no = 0;
        tests++;
        if (valid_o[0] !== 4'b0001 || x_o[0][10:0] !== 11'd640 || gap_o[0][9:0] !== 10'(m_gap[0][0])) begin
            failed++;
            $display("FAIL first_spawn: got valid=%b x0=%0d gap0=%0d, expected 0001/640/%0d",
                     valid_o[0], x_o[0][10:0], gap_o[0][9:0], m_gap[0][0]);
        end
    endtask

    task automatic test_cadence_and_drop();
        logic [10:0] ex_x;
        logic [9:0]  ex_g;
        while (tick_no < 90) begin
            drive_tick(2'b01);
            tick_no++;
            for (int d = 0; d < ND; d++) begin
                for (int s = 0; s < NP; s++) begin
                    ex_x = 11'(m_x[d][s]);
                    ex_g = 10'(m_gap[d][s]);
                    tests++;
                    if (valid_o[d][s] !== m_valid[d][s] ||
                        (m_valid[d][s] && (x_o[d][11*s +: 11] !== ex_x || gap_o[d][10*s +: 10] !== ex_g))) begin
                        failed++;
                        $display("FAIL cadence dut%0d slot%0d tick %0d: got v=%b x=%0d g=%0d expected v=%b x=%0d g=%0d",
                                 d, s, tick_no, valid_o[d][s], $signed(x_o[d][11*s +: 11]), gap_o[d][10*s +: 10],
                                 m_valid[d][s], m_x[d][s], m_gap[d][s]);
                    end
                end
            end
            if (tick_no == 50) begin
                tests++;
                if (valid_o[1] !== 4'b1111 || x_o[1][10:0] !== 11'd590 || x_o[1][43:33] !== 11'd620) begin
                    failed++;
                    $display("FAIL spawn_drop: got valid=%b x0=%0d x3=%0d, expected 1111/590/620",
                             valid_o[1], x_o[1][10:0], x_o[1][43:33]);
                end
            end
        end
        tests++;
        if (valid_o[0] !== 4'b0011 || x_o[0][10:0] !== 11'd460 || x_o[0][21:11] !== 11'd640) begin
            failed++;
            $display("FAIL cadence_90: got valid=%b x0=%0d x1=%0d, expected 0011/460/640",
                     valid_o[0], x_o[0][10:0], x_o[0][21:11]);
        end
    endtask

    task automatic test_scoring();
        int a_pulses = 0;
        while (tick_no < 300) begin
            drive_tick(2'b01);
            tick_no++;
            if (pulse_o[0]) a_pulses++;
            for (int d = 0; d < ND; d++) begin
                tests++;
                if (score_o[d] !== 8'(m_score[d]) || pulse_o[d] !== m_pulse[d] || valid_o[d] !== {m_valid[d][3], m_valid[d][2], m_valid[d][1], m_valid[d][0]}) begin
                    failed++;
                    $display("FAIL score_track dut%0d tick %0d: got score=%0d pulse=%b valid=%b expected %0d/%b/%b%b%b%b",
                             d, tick_no, score_o[d], pulse_o[d], valid_o[d], m_score[d], m_pulse[d],
                             m_valid[d][3], m_valid[d][2], m_valid[d][1], m_valid[d][0]);
                end
            end
            if (tick_no == 266 || tick_no == 267) begin
                tests++;
                if (score_o[0] !== 8'(tick_no - 266) || pulse_o[0] !== 1'(tick_no - 266)) begin
                    failed++;
                    $display("FAIL score_pass tick %0d: got score=%0d pulse=%b expected %0d/%0d",
                             tick_no, score_o[0], pulse_o[0], tick_no - 266, tick_no - 266);
                end
            end
            if (tick_no == 267) begin
                step(1'b0, 2'b01, 1'b0);
                tests++;
                if (pulse_o[0] !== 1'b0 || score_o[0] !== 8'd1) begin
                    failed++;
                    $display("FAIL pulse_width: got pulse=%b score=%0d expected 0/1", pulse_o[0], score_o[0]);
                end
            end
        end
        tests++;
        if (a_pulses != 1 || score_o[0] !== 8'd1) begin
            failed++;
            $display("FAIL single_increment: got pulses=%0d score=%0d expected 1/1", a_pulses, score_o[0]);
        end
        tests++;
        if (score_o[2] !== 8'd255 || pulse_o[2] !== 1'b0) begin
            failed++;
            $display("FAIL saturation: got score=%0d pulse=%b expected 255/0", score_o[2], pulse_o[2]);
        end
    endtask

    task automatic test_reuse();
        while (tick_no < 360) begin
            drive_tick(2'b01);
            tick_no++;
            if (tick_no == 345 || tick_no == 346 || tick_no == 360) begin
                tests++;
                if (valid_o[0][0] !== (tick_no != 346) || (tick_no == 360 && x_o[0][10:0] !== 11'd640)) begin
                    failed++;
                    $display("FAIL slot_reuse tick %0d: got valid=%b x0=%0d expected valid0=%0d",
                             tick_no, valid_o[0], $signed(x_o[0][10:0]), tick_no != 346);
                end
            end
        end
    endtask

    task automatic test_freeze();
        logic [1:0] st;
        for (int i = 0; i < 12; i++) begin
            st = (i % 2 == 1) ? 2'b11 : 2'b10;
            step(1'b0, st, 1'($urandom_range(0, 1)));
            for (int d = 0; d < ND; d++) begin
                tests++;
                if (score_o[d] !== 8'(m_score[d]) || pulse_o[d] !== 1'b0 ||
                    valid_o[d] !== {m_valid[d][3], m_valid[d][2], m_valid[d][1], m_valid[d][0]} ||
                    x_o[d][10:0] !== 11'(m_x[d][0])) begin
                    failed++;
                    $display("FAIL freeze dut%0d cycle %0d: got score=%0d pulse=%b valid=%b x0=%0d expected score=%0d x0=%0d",
                             d, i, score_o[d], pulse_o[d], valid_o[d], $signed(x_o[d][10:0]), m_score[d], m_x[d][0]);
                end
            end
        end
        tests++;
        if (score_o[0] !== 8'd2) begin
            failed++;
            $display("FAIL freeze_score: got %0d expected 2", score_o[0]);
        end
    endtask

    task automatic test_clear_then_resume();
        step(1'b0, 2'b00, 1'b0);
        for (int d = 0; d < ND; d++) begin
            tests++;
            if (valid_o[d] !== '0 || score_o[d] !== 8'd0 || pulse_o[d] !== 1'b0 || x_o[d] !== '0) begin
                failed++;
                $display("FAIL clear dut%0d: got valid=%b score=%0d pulse=%b expected cleared",
                         d, valid_o[d], score_o[d], pulse_o[d]);
            end
        end
        drive_tick(2'b01);
        tests++;
        if (valid_o[0] !== 4'b0001 || gap_o[0][9:0] !== 10'(m_gap[0][0])) begin
            failed++;
            $display("FAIL resume_gap: got valid=%b gap0=%0d expected 0001/%0d", valid_o[0], gap_o[0][9:0], m_gap[0][0]);
        end
    endtask

    task automatic test_midgame_reset();
        repeat (3) drive_tick(2'b01);
        step(1'b1, 2'b01, 1'b1);
        tests++;
        if (valid_o[0] !== '0 || score_o[0] !== 8'd0 || x_o[0] !== '0) begin
            failed++;
            $display("FAIL midgame_reset: got valid=%b score=%0d expected cleared", valid_o[0], score_o[0]);
        end
        test_seed_gap("reseed_gap");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_seed_gap("seed_gap");
        test_start_page();
        test_first_spawn();
        test_cadence_and_drop();
        test_scoring();
        test_reuse();
        test_freeze();
        test_clear_then_resume();
        test_midgame_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
